// File: rtl/rob_dual.sv
// rob_dual: in-order reorder buffer with two commit lanes.
// Entries are allocated at tail, completed out of order by the ALU/branch,
// load and store writeback ports, and retired from head up to two per cycle.
// A committed redirect raises jump_flag; the cycle that sees jump_flag
// flushes the whole buffer.
module rob_dual #(
    parameter int ROB_LOG = 4,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 issue_valid,
    input  logic                 issue_store,
    input  logic                 issue_branch,
    input  logic [4:0]           issue_dest,
    output logic [ROB_LOG-1:0]   issue_id,
    output logic                 full,
    output logic [ROB_LOG:0]     count,
    input  logic                 exc_valid,
    input  logic [ROB_LOG-1:0]   exc_id,
    input  logic [DATA_W-1:0]    exc_value,
    input  logic                 exc_redirect,
    input  logic [DATA_W-1:0]    exc_topc,
    input  logic                 lsb_valid,
    input  logic [ROB_LOG-1:0]   lsb_id,
    input  logic [DATA_W-1:0]    lsb_value,
    input  logic                 store_valid,
    input  logic [ROB_LOG-1:0]   store_id,
    input  logic [ROB_LOG-1:0]   qa_id,
    input  logic [ROB_LOG-1:0]   qb_id,
    output logic                 qa_ready,
    output logic                 qb_ready,
    output logic [DATA_W-1:0]    qa_value,
    output logic [DATA_W-1:0]    qb_value,
    output logic [1:0]           reg_en,
    output logic [9:0]           reg_index,
    output logic [2*ROB_LOG-1:0] reg_id,
    output logic [2*DATA_W-1:0]  reg_value,
    output logic                 store_go,
    output logic [ROB_LOG-1:0]   store_go_id,
    output logic                 jump_flag,
    output logic [DATA_W-1:0]    jump_pc
);
    localparam int DEPTH = 2 ** ROB_LOG;
    localparam logic [ROB_LOG:0] DEPTH_C = (ROB_LOG+1)'(DEPTH);
    localparam logic [ROB_LOG:0] TWO_C   = (ROB_LOG+1)'(2);

    logic [DEPTH-1:0]             e_ready, e_redir, e_store, e_branch;
    logic [DEPTH-1:0][4:0]        e_dest;
    logic [DEPTH-1:0][DATA_W-1:0] e_value, e_topc;
    logic [ROB_LOG-1:0]           head, tail;

    logic                      issue_acc;
    logic [1:0][ROB_LOG-1:0]   lane_idx;
    logic [1:0]                lane_commit;
    logic [ROB_LOG:0]          count_next;

    logic [1:0]                reg_en_n;
    logic [9:0]                reg_index_n;
    logic [2*ROB_LOG-1:0]      reg_id_n;
    logic [2*DATA_W-1:0]       reg_value_n;
    logic                      store_go_n;
    logic [ROB_LOG-1:0]        store_go_id_n;
    logic                      jump_n;
    logic [DATA_W-1:0]         jump_pc_n;

    assign issue_id    = tail;
    assign full        = (count == DEPTH_C);
    assign issue_acc   = issue_valid && !full;
    assign lane_idx[0] = head;
    assign lane_idx[1] = head + ROB_LOG'(1);

    // Lane 1 only rides along with lane 0 when it cannot be squashed by a
    // lane-0 redirect and the store port is not needed twice.
    assign lane_commit[0] = (count != '0) && e_ready[lane_idx[0]];
    assign lane_commit[1] = lane_commit[0] && (count >= TWO_C) && e_ready[lane_idx[1]]
                            && !e_redir[lane_idx[0]]
                            && !(e_store[lane_idx[0]] && e_store[lane_idx[1]]);

    assign count_next = count + (ROB_LOG+1)'(issue_acc)
                              - (ROB_LOG+1)'(lane_commit[0])
                              - (ROB_LOG+1)'(lane_commit[1]);

    // Operand lookup: stored result first, then same-cycle exc, then lsb.
    function automatic logic [DATA_W:0] lookup(input logic [ROB_LOG-1:0] id);
        if (e_ready[id])                  return {1'b1, e_value[id]};
        else if (exc_valid && exc_id == id) return {1'b1, exc_value};
        else if (lsb_valid && lsb_id == id) return {1'b1, lsb_value};
        else                              return '0;
    endfunction

    assign {qa_ready, qa_value} = lookup(qa_id);
    assign {qb_ready, qb_value} = lookup(qb_id);

    // Build next commit outputs from the entries each lane retires.
    always_comb begin
        reg_en_n      = '0;
        reg_index_n   = '0;
        reg_id_n      = '0;
        reg_value_n   = '0;
        store_go_n    = 1'b0;
        store_go_id_n = '0;
        jump_n        = 1'b0;
        jump_pc_n     = '0;
        for (int k = 0; k < 2; k++) begin
            if (lane_commit[k]) begin
                if (e_store[lane_idx[k]]) begin
                    store_go_n    = 1'b1;
                    store_go_id_n = lane_idx[k];
                end else if (!e_branch[lane_idx[k]]) begin
                    reg_en_n[k]                       = 1'b1;
                    reg_index_n[k*5 +: 5]             = e_dest[lane_idx[k]];
                    reg_id_n[k*ROB_LOG +: ROB_LOG]    = lane_idx[k];
                    reg_value_n[k*DATA_W +: DATA_W]   = e_value[lane_idx[k]];
                end
                if (e_redir[lane_idx[k]] && !jump_n) begin
                    jump_n    = 1'b1;
                    jump_pc_n = e_topc[lane_idx[k]];
                end
            end
        end
    end

    // Pointers, occupancy and entry state; a pending jump flushes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_ready <= '0;
            e_redir <= '0;
        end else if (rdy) begin
            if (jump_flag) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                e_ready <= '0;
                e_redir <= '0;
            end else begin
                head  <= head + ROB_LOG'(lane_commit[0]) + ROB_LOG'(lane_commit[1]);
                count <= count_next;
                if (issue_acc) begin
                    tail           <= tail + ROB_LOG'(1);
                    e_ready[tail]  <= 1'b0;
                    e_redir[tail]  <= 1'b0;
                    e_store[tail]  <= issue_store;
                    e_branch[tail] <= issue_branch;
                    e_dest[tail]   <= issue_dest;
                end
                if (store_valid) e_ready[store_id] <= 1'b1;
                if (lsb_valid) begin
                    e_ready[lsb_id] <= 1'b1;
                    e_value[lsb_id] <= lsb_value;
                end
                // exc is written last so it wins a same-id collision.
                if (exc_valid) begin
                    e_ready[exc_id] <= 1'b1;
                    e_value[exc_id] <= exc_value;
                    e_redir[exc_id] <= exc_redirect;
                    e_topc[exc_id]  <= exc_topc;
                end
            end
        end
    end

    // Commit outputs are registered one cycle after the decision.
    always_ff @(posedge clk) begin
        if (!rst_n || (rdy && jump_flag)) begin
            reg_en      <= '0;
            reg_index   <= '0;
            reg_id      <= '0;
            reg_value   <= '0;
            store_go    <= 1'b0;
            store_go_id <= '0;
            jump_flag   <= 1'b0;
            jump_pc     <= '0;
        end else if (rdy) begin
            reg_en      <= reg_en_n;
            reg_index   <= reg_index_n;
            reg_id      <= reg_id_n;
            reg_value   <= reg_value_n;
            store_go    <= store_go_n;
            store_go_id <= store_go_id_n;
            jump_flag   <= jump_n;
            jump_pc     <= jump_pc_n;
        end
    end
endmodule
